// File: rtl/nv_nvdla_sdp_wdma_dat_pack.sv
// SDP write-DMA data packer: merges per-lane atom streams round-robin behind a
// command packet, or drops them in flying mode, and signals layer completion.
module nv_nvdla_sdp_wdma_dat_pack #(
  parameter int AM_DW    = 256,
  parameter int NUM_LANE = 4,
  parameter int ADDR_W   = 64,
  parameter int SIZE_W   = 13
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         op_load,
  input  logic                         reg2dp_output_dst,
  input  logic                         reg2dp_interrupt_ptr,
  input  logic                         cmd_pvld,
  output logic                         cmd_prdy,
  input  logic [ADDR_W+SIZE_W:0]       cmd_pd,
  input  logic [NUM_LANE-1:0]          lane_pvld,
  output logic [NUM_LANE-1:0]          lane_prdy,
  input  logic [NUM_LANE*AM_DW-1:0]    lane_pd,
  output logic                         dma_wr_req_vld,
  input  logic                         dma_wr_req_rdy,
  output logic [AM_DW:0]               dma_wr_req_pd,
  output logic                         dp2reg_done,
  output logic                         intr_req_pvld,
  output logic                         intr_req_ptr,
  output logic [31:0]                  dp2reg_beat_cnt
);

  localparam int CMD_W = ADDR_W + SIZE_W + 1;
  localparam int LW    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Every interface is valid/ready: a transfer happens on a rising clock edge
  // where both are high; a producer holds valid and payload until accepted.

  logic [1:0]        state;
  logic              rst_done;
  logic [CMD_W-1:0]  cmd_q;
  logic              dst_q;
  logic [SIZE_W-1:0] beat_left;
  logic [LW-1:0]     lane_ptr;
  logic              out_vld;
  logic              out_last;
  logic [AM_DW:0]    out_pd;
  logic [31:0]       beat_cnt;
  logic              ptr_q;
  logic              intr_ptr_q;
  logic              done_q;

  logic              out_free;
  logic              cmd_acc;
  logic              lane_rdy;
  logic              lane_cur_vld;
  logic              lane_acc;
  logic              load_cmd;
  logic              load_dat;
  logic              beat_last;
  logic              done_point;
  logic [AM_DW-1:0]  lane_sel;
  logic [AM_DW-1:0]  cmd_word;

  // rst_done keeps cmd_prdy low while reset is held so every output reads 0.
  assign cmd_prdy   = rst_done && (state == ST_IDLE);
  assign out_free   = !out_vld || dma_wr_req_rdy;
  assign cmd_acc    = cmd_pvld && cmd_prdy;
  assign lane_rdy   = (state == ST_DATA) && (dst_q || out_free);
  assign lane_acc   = lane_rdy && lane_cur_vld;
  assign load_cmd   = (state == ST_CMD) && out_free;
  assign load_dat   = lane_acc && !dst_q;
  assign beat_last  = (beat_left == '0);
  assign done_point = (dst_q && lane_acc && beat_last && cmd_q[CMD_W-1]) ||
                      (out_vld && dma_wr_req_rdy && out_last);

  always_comb begin
    lane_sel     = '0;
    lane_cur_vld = 1'b0;
    lane_prdy    = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (lane_ptr == LW'(i)) begin
        lane_sel     = lane_pd[i*AM_DW +: AM_DW];
        lane_cur_vld = lane_pvld[i];
        lane_prdy[i] = lane_rdy;
      end
    end
  end

  always_comb begin
    cmd_word = '0;
    cmd_word[CMD_W-1:0] = cmd_q;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state     <= ST_IDLE;
      rst_done  <= 1'b0;
      cmd_q     <= '0;
      dst_q     <= 1'b0;
      beat_left <= '0;
      lane_ptr  <= '0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cmd_acc) begin
            cmd_q     <= cmd_pd;
            dst_q     <= reg2dp_output_dst;
            beat_left <= cmd_pd[ADDR_W +: SIZE_W];
            lane_ptr  <= '0;
            state     <= reg2dp_output_dst ? ST_DATA : ST_CMD;
          end
        end
        ST_CMD: begin
          if (load_cmd) state <= ST_DATA;
        end
        ST_DATA: begin
          if (lane_acc) begin
            lane_ptr <= (lane_ptr == LW'(NUM_LANE - 1)) ? '0 : lane_ptr + 1'b1;
            if (beat_last) state <= ST_IDLE;
            else           beat_left <= beat_left - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single-entry output register; a load may replace an entry leaving this cycle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_pd   <= '0;
    end else if (load_cmd) begin
      out_vld  <= 1'b1;
      out_last <= 1'b0;
      out_pd   <= {1'b0, cmd_word};
    end else if (load_dat) begin
      out_vld  <= 1'b1;
      out_last <= beat_last && cmd_q[CMD_W-1];
      out_pd   <= {1'b1, lane_sel};
    end else if (dma_wr_req_rdy) begin
      out_vld  <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt   <= '0;
      ptr_q      <= 1'b0;
      intr_ptr_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (op_load) begin
        beat_cnt <= lane_acc ? 32'd1 : 32'd0;
        ptr_q    <= reg2dp_interrupt_ptr;
      end else if (lane_acc && (beat_cnt != 32'hFFFF_FFFF)) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      done_q <= done_point;
      if (done_point) intr_ptr_q <= ptr_q;
    end
  end

  assign dma_wr_req_vld  = out_vld;
  assign dma_wr_req_pd   = out_pd;
  assign dp2reg_done     = done_q;
  assign intr_req_pvld   = done_q;
  assign intr_req_ptr    = intr_ptr_q;
  assign dp2reg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_dat_pack.sv
// Directed bench for the SDP write-DMA data packer: command/data ordering,
// back-pressure, flying mode, completion pulses, lane bubbles and reset.
module tb_nv_nvdla_sdp_wdma_dat_pack;

  localparam int AM_DW    = 256;
  localparam int NUM_LANE = 4;
  localparam int ADDR_W   = 64;
  localparam int SIZE_W   = 13;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      op_load;
  logic                      reg2dp_output_dst;
  logic                      reg2dp_interrupt_ptr;
  logic                      cmd_pvld;
  logic                      cmd_prdy;
  logic [ADDR_W+SIZE_W:0]    cmd_pd;
  logic [NUM_LANE-1:0]       lane_pvld;
  logic [NUM_LANE-1:0]       lane_prdy;
  logic [NUM_LANE*AM_DW-1:0] lane_pd;
  logic                      dma_wr_req_vld;
  logic                      dma_wr_req_rdy;
  logic [AM_DW:0]            dma_wr_req_pd;
  logic                      dp2reg_done;
  logic                      intr_req_pvld;
  logic                      intr_req_ptr;
  logic [31:0]               dp2reg_beat_cnt;

  logic toggle_mode = 1'b0;
  logic tog = 1'b0;
  logic rdy_lvl = 1'b1;
  assign dma_wr_req_rdy = toggle_mode ? tog : rdy_lvl;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(negedge clk) tog <= ~tog;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  nv_nvdla_sdp_wdma_dat_pack #(
    .AM_DW(AM_DW), .NUM_LANE(NUM_LANE), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)
  ) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .op_load             (op_load),
    .reg2dp_output_dst   (reg2dp_output_dst),
    .reg2dp_interrupt_ptr(reg2dp_interrupt_ptr),
    .cmd_pvld            (cmd_pvld),
    .cmd_prdy            (cmd_prdy),
    .cmd_pd              (cmd_pd),
    .lane_pvld           (lane_pvld),
    .lane_prdy           (lane_prdy),
    .lane_pd             (lane_pd),
    .dma_wr_req_vld      (dma_wr_req_vld),
    .dma_wr_req_rdy      (dma_wr_req_rdy),
    .dma_wr_req_pd       (dma_wr_req_pd),
    .dp2reg_done         (dp2reg_done),
    .intr_req_pvld       (intr_req_pvld),
    .intr_req_ptr        (intr_req_ptr),
    .dp2reg_beat_cnt     (dp2reg_beat_cnt)
  );

  // ---------------- lane sources and monitor ----------------
  int lane_seq[NUM_LANE];
  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    assign lane_pd[g*AM_DW +: AM_DW] = AM_DW'({8'(g), 24'(lane_seq[g])});
  end

  logic [AM_DW:0] got_q[$];
  int             got_cyc[$];
  int             lane_hs_cyc[$];
  int             done_cyc[$];
  int             cyc = 0;
  int             lane_hs_total = 0;
  int             done_cnt = 0;
  int             intr_cnt = 0;
  int             vld_cycles = 0;
  int             stall_err = 0;
  logic           hold_v = 1'b0;
  logic [AM_DW:0] hold_pd;

  always @(posedge clk) begin
    if (dma_wr_req_vld && dma_wr_req_rdy) begin
      got_q.push_back(dma_wr_req_pd);
      got_cyc.push_back(cyc);
    end
    for (int i = 0; i < NUM_LANE; i++) begin
      if (lane_pvld[i] && lane_prdy[i]) begin
        lane_seq[i] <= lane_seq[i] + 1;
        lane_hs_total++;
        lane_hs_cyc.push_back(cyc);
      end
    end
    if (dp2reg_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (intr_req_pvld) intr_cnt++;
    if (dma_wr_req_vld) vld_cycles++;
    if (hold_v && rstn && (!dma_wr_req_vld || dma_wr_req_pd !== hold_pd)) stall_err++;
    hold_v  = dma_wr_req_vld && !dma_wr_req_rdy;
    hold_pd = dma_wr_req_pd;
    cyc++;
  end

  // ---------------- expected packets ----------------
  function automatic logic [AM_DW:0] exp_cmd(input logic last, input logic [SIZE_W-1:0] size,
                                             input logic [ADDR_W-1:0] addr);
    logic [AM_DW-1:0] w;
    w = AM_DW'({last, size, addr});
    return {1'b0, w};
  endfunction

  function automatic logic [AM_DW:0] exp_dat(input int lane, input int seq);
    logic [AM_DW-1:0] w;
    w = AM_DW'({8'(lane), 24'(seq)});
    return {1'b1, w};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic last, input logic [SIZE_W-1:0] size,
                          input logic [ADDR_W-1:0] addr, input logic dst);
    int n;
    @(negedge clk);
    reg2dp_output_dst = dst;
    cmd_pd   = {last, size, addr};
    cmd_pvld = 1'b1;
    n = 0;
    while (!cmd_prdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!cmd_prdy) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_prdy=%0b after %0d cycles, required 1", cmd_prdy, n);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_pvld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_prdy && !dma_wr_req_vld) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL idle_timeout: block still busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_op_load(input logic ptr);
    @(negedge clk);
    op_load = 1'b1;
    reg2dp_interrupt_ptr = ptr;
    @(negedge clk);
    op_load = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 7;
    if (cmd_prdy !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_prdy: got %0b, required 0", cmd_prdy); end
    if (lane_prdy !== 4'b0) begin n_fail++; $display("FAIL rst_lane_prdy: got %b, required 0000", lane_prdy); end
    if (dma_wr_req_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %0b, required 0", dma_wr_req_vld); end
    if (dp2reg_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b, required 0", dp2reg_done); end
    if (intr_req_pvld !== 1'b0) begin n_fail++; $display("FAIL rst_intr: got %0b, required 0", intr_req_pvld); end
    if (intr_req_ptr !== 1'b0) begin n_fail++; $display("FAIL rst_intr_ptr: got %0b, required 0", intr_req_ptr); end
    if (dp2reg_beat_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_beat_cnt: got %0d, required 0", dp2reg_beat_cnt); end
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (cmd_prdy !== 1'b1) begin n_fail++; $display("FAIL rst_release_cmd_prdy: got %0b, required 1", cmd_prdy); end
  endtask

  task automatic test_dma_stream(input bit toggle, input string tag);
    int s, b[NUM_LANE], d0, se0;
    for (int i = 0; i < NUM_LANE; i++) b[i] = lane_seq[i];
    s = got_q.size(); d0 = done_cnt; se0 = stall_err;
    toggle_mode = toggle;
    send_cmd(1'b0, 13'd5, 64'h1000, 1'b0);
    wait_idle();
    toggle_mode = 1'b0;
    n_cmp++;
    if (got_q.size() - s !== 7) begin
      n_fail++; $display("FAIL %s_count: got %0d packets, required 7", tag, got_q.size() - s);
    end else begin
      n_cmp++;
      if (got_q[s] !== exp_cmd(1'b0, 13'd5, 64'h1000)) begin
        n_fail++; $display("FAIL %s_cmd_pkt: got %h, required %h", tag, got_q[s], exp_cmd(1'b0, 13'd5, 64'h1000));
      end
      for (int j = 0; j < 6; j++) begin
        n_cmp++;
        if (got_q[s+1+j] !== exp_dat(j % 4, b[j % 4] + j / 4)) begin
          n_fail++; $display("FAIL %s_data%0d: got %h, required %h", tag, j, got_q[s+1+j], exp_dat(j % 4, b[j % 4] + j / 4));
        end
      end
      if (!toggle) begin
        n_cmp++;
        if (got_cyc[s+6] - got_cyc[s] !== 6) begin
          n_fail++; $display("FAIL %s_throughput: 7 packets spanned %0d cycles, required 6", tag, got_cyc[s+6] - got_cyc[s]);
        end
      end
    end
    n_cmp += 2;
    if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL %s_no_done: got %0d done cycles, required 0", tag, done_cnt - d0); end
    if (stall_err - se0 !== 0) begin n_fail++; $display("FAIL %s_stall_stable: got %0d unstable stalls, required 0", tag, stall_err - se0); end
  endtask

  task automatic test_flying();
    int v0, h0, hc0, d0, i0;
    pulse_op_load(1'b0);
    v0 = vld_cycles; h0 = lane_hs_total; hc0 = lane_hs_cyc.size(); d0 = done_cnt; i0 = intr_cnt;
    send_cmd(1'b1, 13'd7, 64'h2000, 1'b1);
    wait_idle();
    n_cmp += 6;
    if (vld_cycles - v0 !== 0) begin n_fail++; $display("FAIL fly_no_vld: got %0d vld cycles, required 0", vld_cycles - v0); end
    if (lane_hs_total - h0 !== 8) begin n_fail++; $display("FAIL fly_beats: got %0d, required 8", lane_hs_total - h0); end
    else if (lane_hs_cyc[hc0+7] - lane_hs_cyc[hc0] !== 7) begin
      n_fail++; $display("FAIL fly_rate: 8 beats spanned %0d cycles, required 7", lane_hs_cyc[hc0+7] - lane_hs_cyc[hc0]);
    end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL fly_done: got %0d cycles, required 1", done_cnt - d0); end
    if (intr_cnt - i0 !== 1) begin n_fail++; $display("FAIL fly_intr: got %0d cycles, required 1", intr_cnt - i0); end
    if (dp2reg_beat_cnt !== 32'd8) begin n_fail++; $display("FAIL fly_beat_cnt: got %0d, required 8", dp2reg_beat_cnt); end
    if (intr_req_ptr !== 1'b0) begin n_fail++; $display("FAIL fly_intr_ptr: got %0b, required 0", intr_req_ptr); end
  endtask

  task automatic test_last_single();
    int s, b0, d0, dc0;
    pulse_op_load(1'b1);
    b0 = lane_seq[0]; s = got_q.size(); d0 = done_cnt; dc0 = done_cyc.size();
    send_cmd(1'b1, 13'd0, 64'h3000, 1'b0);
    reg2dp_output_dst = 1'b1;
    wait_idle();
    reg2dp_output_dst = 1'b0;
    n_cmp += 4;
    if (got_q.size() - s !== 2) begin
      n_fail++; $display("FAIL last_count: got %0d packets, required 2", got_q.size() - s);
    end else begin
      n_cmp += 2;
      if (got_q[s] !== exp_cmd(1'b1, 13'd0, 64'h3000)) begin
        n_fail++; $display("FAIL last_cmd_pkt: got %h, required %h", got_q[s], exp_cmd(1'b1, 13'd0, 64'h3000));
      end
      if (got_q[s+1] !== exp_dat(0, b0)) begin
        n_fail++; $display("FAIL last_data: got %h, required %h", got_q[s+1], exp_dat(0, b0));
      end
      if (done_cyc.size() > dc0) begin
        n_cmp++;
        if (done_cyc[dc0] !== got_cyc[s+1] + 1) begin
          n_fail++; $display("FAIL last_done_timing: done at cycle %0d, required %0d", done_cyc[dc0], got_cyc[s+1] + 1);
        end
      end
    end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL last_done: got %0d cycles, required 1", done_cnt - d0); end
    if (intr_req_ptr !== 1'b1) begin n_fail++; $display("FAIL last_intr_ptr: got %0b, required 1", intr_req_ptr); end
    if (dp2reg_beat_cnt !== 32'd1) begin n_fail++; $display("FAIL last_beat_cnt: got %0d, required 1", dp2reg_beat_cnt); end
  endtask

  task automatic test_lane_bubble();
    int s, b[NUM_LANE], n;
    for (int i = 0; i < NUM_LANE; i++) b[i] = lane_seq[i];
    s = got_q.size();
    lane_pvld = 4'b1011;
    send_cmd(1'b0, 13'd3, 64'h4000, 1'b0);
    n = 0;
    while (lane_seq[1] != b[1] + 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    n_cmp += 5;
    if (lane_prdy !== 4'b0100) begin n_fail++; $display("FAIL bubble_prdy: got %b, required 0100", lane_prdy); end
    for (int i = 0; i < NUM_LANE; i++) begin
      if (lane_seq[i] - b[i] !== ((i < 2) ? 1 : 0)) begin
        n_fail++; $display("FAIL bubble_lane%0d: got %0d beats, required %0d", i, lane_seq[i] - b[i], (i < 2) ? 1 : 0);
      end
    end
    lane_pvld = 4'hF;
    wait_idle();
    n_cmp++;
    if (got_q.size() - s !== 5) begin
      n_fail++; $display("FAIL bubble_count: got %0d packets, required 5", got_q.size() - s);
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (got_q[s+1+j] !== exp_dat(j, b[j])) begin
          n_fail++; $display("FAIL bubble_data%0d: got %h, required %h", j, got_q[s+1+j], exp_dat(j, b[j]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int h0, n, s, b0, b1, d0;
    h0 = lane_hs_total;
    send_cmd(1'b0, 13'd5, 64'h5000, 1'b0);
    n = 0;
    while (lane_hs_total - h0 < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rstn = 1'b0;
    #1;
    n_cmp += 6;
    if (dma_wr_req_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld: got %0b, required 0", dma_wr_req_vld); end
    if (dma_wr_req_pd !== '0) begin n_fail++; $display("FAIL midrst_pd: got %h, required 0", dma_wr_req_pd); end
    if (lane_prdy !== 4'b0) begin n_fail++; $display("FAIL midrst_lane_prdy: got %b, required 0000", lane_prdy); end
    if (cmd_prdy !== 1'b0) begin n_fail++; $display("FAIL midrst_cmd_prdy: got %0b, required 0", cmd_prdy); end
    if (dp2reg_beat_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_beat_cnt: got %0d, required 0", dp2reg_beat_cnt); end
    if (intr_req_ptr !== 1'b0) begin n_fail++; $display("FAIL midrst_intr_ptr: got %0b, required 0", intr_req_ptr); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_prdy !== 1'b1) begin n_fail++; $display("FAIL midrst_release: cmd_prdy got %0b, required 1", cmd_prdy); end
    b0 = lane_seq[0]; b1 = lane_seq[1]; s = got_q.size(); d0 = done_cnt;
    send_cmd(1'b1, 13'd1, 64'h6000, 1'b0);
    wait_idle();
    n_cmp += 3;
    if (got_q.size() - s !== 3) begin
      n_fail++; $display("FAIL midrst_count: got %0d packets, required 3", got_q.size() - s);
    end else begin
      n_cmp += 2;
      if (got_q[s] !== exp_cmd(1'b1, 13'd1, 64'h6000)) begin
        n_fail++; $display("FAIL midrst_cmd_pkt: got %h, required %h", got_q[s], exp_cmd(1'b1, 13'd1, 64'h6000));
      end
      if (got_q[s+1] !== exp_dat(0, b0) || got_q[s+2] !== exp_dat(1, b1)) begin
        n_fail++; $display("FAIL midrst_data: got %h / %h, required %h / %h", got_q[s+1], got_q[s+2], exp_dat(0, b0), exp_dat(1, b1));
      end
    end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midrst_done: got %0d cycles, required 1", done_cnt - d0); end
    if (dp2reg_beat_cnt !== 32'd2) begin n_fail++; $display("FAIL midrst_beat_cnt: got %0d, required 2", dp2reg_beat_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    op_load = 1'b0;
    reg2dp_output_dst = 1'b0;
    reg2dp_interrupt_ptr = 1'b0;
    cmd_pvld = 1'b0;
    cmd_pd = '0;
    lane_pvld = 4'hF;
    test_reset();
    test_dma_stream(1'b0, "stream");
    test_dma_stream(1'b1, "backpressure");
    test_flying();
    test_last_single();
    test_lane_bubble();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_sdp_wdma_dat_pack.md
Name: nv_nvdla_sdp_wdma_dat_pack

Overview:
- Parametrised write-DMA data engine for SDP; supports NUM_LANE data lanes.
- Takes write commands and per-lane atom streams from the upstream data FIFOs, merges them round-robin, and emits the DMA write-request stream: one command packet followed by size+1 data packets.
- Supports a flying mode that consumes and drops data without issuing DMA traffic.
- Generates done/interrupt at layer end and keeps a beat counter for status.

Parameters:
- AM_DW, 256: atom (lane) data width in bits.
- NUM_LANE, 4: number of data lanes; range 1..8.
- ADDR_W, 64: DMA address width.
- SIZE_W, 13: command size field width, in beats minus one.
- Legality: AM_DW >= ADDR_W+SIZE_W+1 is required.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- op_load  in  1  layer start pulse
- reg2dp_output_dst  in  1  0=DMA to memory, 1=flying (drop)
- reg2dp_interrupt_ptr  in  1  interrupt pointer for the layer
- cmd_pvld  in  1  command valid
- cmd_prdy  out  1  command ready
- cmd_pd  in  ADDR_W+SIZE_W+1  {last, size, addr}, with addr in the LSBs
- lane_pvld  in  NUM_LANE  per-lane valid
- lane_prdy  out  NUM_LANE  per-lane ready
- lane_pd  in  NUM_LANE*AM_DW  lane i at bits [i*AM_DW +: AM_DW]
- dma_wr_req_vld  out  1  request valid
- dma_wr_req_rdy  in  1  request ready
- dma_wr_req_pd  out  AM_DW+1  bit AM_DW = type (0 cmd, 1 data); cmd payload = {zero pad, last, size, addr}
- dp2reg_done  out  1  layer done pulse
- intr_req_pvld  out  1  interrupt request pulse
- intr_req_ptr  out  1  interrupt pointer
- dp2reg_beat_cnt  out  32  data beats consumed this layer

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, output register empty, lane pointer 0, counters 0.

FSM states:
- IDLE: cmd_prdy=1. On a cmd handshake, latch addr/size/last, clear beat_left to size and lane_ptr to 0. Go to CMD if dst=0, else DATA.
- CMD: load the command packet into the output register when it is free; then go to DATA.
- DATA: each beat consumes lane[lane_ptr]. lane_prdy[lane_ptr] = output register free (dst=0) or 1 (dst=1); all other lane_prdy bits are 0.
  - On a lane handshake: lane_ptr = (lane_ptr+1) mod NUM_LANE (wraps at NUM_LANE-1), beat_left decrements, beat counter increments.
  - When beat_left==0 is consumed, go to IDLE.

Output register:
- Single entry, 1-cycle latency from load to dma_wr_req_vld.
- "Free" means empty, or vld&&rdy in the same cycle (back-to-back loads allowed: full throughput of 1 packet/cycle).
- pd is held stable while vld&&!rdy.

Flying mode:
- No packets are loaded; dma_wr_req_vld stays 0; data is dropped at up to 1 beat/cycle.

Layer completion (last=1 command):
- Done point: the last data beat is accepted downstream (dst=0) or consumed (dst=1).
- The cycle after the done point: dp2reg_done=1 and intr_req_pvld=1 for exactly 1 cycle; intr_req_ptr = latched ptr, held until the next pulse.

op_load:
- Latches reg2dp_interrupt_ptr and clears dp2reg_beat_cnt.
- Does not abort an in-flight command.
- If op_load coincides with a counter increment, the result is cnt=1 (clear, then count).

Other rules:
- dp2reg_beat_cnt saturates at 0xFFFFFFFF.
- reg2dp_output_dst is sampled at the IDLE cmd handshake; changes mid-command are ignored.
- Lane bubbles: stall in DATA without advancing lane_ptr; lanes are never skipped.
- Async reset mid-command drops the command and any partial data; nothing is retained.

Test Plan:
1. dst=0, NUM_LANE=4, cmd {last=0, size=5, addr=0x1000}, all lanes valid, rdy=1 -> 1 cmd packet then 6 data packets from lanes 0,1,2,3,0,1 on consecutive cycles; no done pulse.
2. Same stimulus with dma_wr_req_rdy toggling 1/0 each cycle -> pd stable while stalled, no beat lost or duplicated, 6 data beats total.
3. dst=1, cmd {last=1, size=7} -> dma_wr_req_vld stays 0; 8 lane beats consumed over 8 cycles; dp2reg_done and intr_req_pvld pulse once; dp2reg_beat_cnt=8.
4. op_load with reg2dp_interrupt_ptr=1, then a last=1 cmd of size 0 in dst=0 -> 2 packets emitted; 1 cycle after the data beat handshake, done=1 and intr_req_ptr=1.
5. Lane 2 valid withheld for 10 cycles in the middle of a size=3 command -> FSM stalls at lane_ptr=2 with lane_prdy=4'b0100 and no other lane consumed; resumes when valid rises.
6. nvdla_core_rstn asserted in DATA with 3 beats outstanding -> next cycle all outputs 0, cmd_prdy=1 after release; a fresh command completes normally.
